// File: rtl/mem_arbiter.sv
// Two-port req/ack arbiter sequencing a single-ported memory with one-cycle registered reads.
// Optional build macro MEM_ARB_FIXED_PRI_EN: port 0 always wins a tie (default is round-robin).
module mem_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             we0,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] wdata0,
  output logic             ack0,
  output logic [WIDTH-1:0] rdata0,
  input  logic             req1,
  input  logic             we1,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] wdata1,
  output logic             ack1,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] mem_address,
  output logic [WIDTH-1:0] mem_wr_data,
  output logic             mem_write,
  input  logic [WIDTH-1:0] mem_rd_data,
  output logic             busy,
  output logic             owner
);

  // state  | meaning
  // IDLE   | waiting for a request; arbitration happens here
  // ACCESS | memory sees the address (and write strobe for a write)
  // RDWAIT | registered read data valid; captured at the end of this cycle
  // DONE   | one-cycle ack to the owner
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RDWAIT = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0] state;
  logic       any_req;
  logic       win;

`ifndef MEM_ARB_FIXED_PRI_EN
  logic       last_gnt;
`endif

  always_comb begin
    any_req = req0 | req1;
`ifdef MEM_ARB_FIXED_PRI_EN
    win = ~req0;
`else
    win = (req0 & req1) ? ~last_gnt : req1;
`endif
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      mem_address <= '0;
      mem_wr_data <= '0;
      mem_write   <= 1'b0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
      owner       <= 1'b0;
`ifndef MEM_ARB_FIXED_PRI_EN
      last_gnt    <= 1'b1;
`endif
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          mem_write <= 1'b0;
          if (any_req) begin
            owner       <= win;
`ifndef MEM_ARB_FIXED_PRI_EN
            last_gnt    <= win;
`endif
            mem_address <= win ? addr1  : addr0;
            mem_wr_data <= win ? wdata1 : wdata0;
            mem_write   <= win ? we1    : we0;
            state       <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // mem_write still carries the latched direction of this transaction
          mem_write <= 1'b0;
          if (mem_write) begin
            ack0  <= ~owner;
            ack1  <= owner;
            state <= ST_DONE;
          end else begin
            state <= ST_RDWAIT;
          end
        end
        ST_RDWAIT: begin
          if (owner) rdata1 <= mem_rd_data;
          else       rdata0 <= mem_rd_data;
          ack0  <= ~owner;
          ack1  <= owner;
          state <= ST_DONE;
        end
        ST_DONE: begin
          mem_write <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          mem_write <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
